// File: rtl/ptw_req_arbiter_if.sv
// ptw_req_arbiter_if
// Bundles the TLB-miss, walker-handshake, completion and perf-counter signals
// between the PTW request arbiter and its surroundings (I-TLB, D-TLB, walker,
// perf-counter block).
//
// Parameters:
//   VLEN  - virtual address width (Sv32 => 32)
//   CNT_W - width of each saturating walk counter
//
// Modports:
//   master - the arbiter's view (drives the walk request, done pulses, counters)
//   slave  - the environment's view (TLBs and walker)
//
// Signals (direction given from the arbiter's side):
//   flush_i            in   sfence.vma / mode-change flush
//   itlb_miss_i        in   I-TLB miss level, held until itlb_done_o or flush
//   itlb_vaddr_i       in   I-TLB miss address
//   dtlb_miss_i        in   D-TLB miss level, held until dtlb_done_o or flush
//   dtlb_vaddr_i       in   D-TLB miss address
//   dtlb_is_store_i    in   D-TLB miss caused by a store/AMO
//   ptw_req_valid_o    out  walk request valid
//   ptw_req_ready_i    in   walker accepts request
//   ptw_req_vaddr_o    out  captured miss address
//   ptw_req_is_instr_o out  1 = instruction walk
//   ptw_req_is_store_o out  store walk (0 for instruction walks)
//   ptw_done_i         in   walk finished, single-cycle pulse
//   ptw_error_i        in   qualifies ptw_done_i: page/access fault
//   itlb_done_o        out  completion pulse to the I-TLB
//   dtlb_done_o        out  completion pulse to the D-TLB
//   done_error_o       out  ptw_error_i while a done pulse is high, else 0
//   ptw_busy_o         out  arbiter not idle
//   itlb_walk_cnt_o    out  accepted I-walks, saturating
//   dtlb_walk_cnt_o    out  accepted D-walks, saturating
interface ptw_req_arbiter_if #(
  parameter int VLEN  = 32,
  parameter int CNT_W = 16
);

  logic             flush_i;
  logic             itlb_miss_i;
  logic [VLEN-1:0]  itlb_vaddr_i;
  logic             dtlb_miss_i;
  logic [VLEN-1:0]  dtlb_vaddr_i;
  logic             dtlb_is_store_i;
  logic             ptw_req_valid_o;
  logic             ptw_req_ready_i;
  logic [VLEN-1:0]  ptw_req_vaddr_o;
  logic             ptw_req_is_instr_o;
  logic             ptw_req_is_store_o;
  logic             ptw_done_i;
  logic             ptw_error_i;
  logic             itlb_done_o;
  logic             dtlb_done_o;
  logic             done_error_o;
  logic             ptw_busy_o;
  logic [CNT_W-1:0] itlb_walk_cnt_o;
  logic [CNT_W-1:0] dtlb_walk_cnt_o;

  modport master (
    input  flush_i,
    input  itlb_miss_i,
    input  itlb_vaddr_i,
    input  dtlb_miss_i,
    input  dtlb_vaddr_i,
    input  dtlb_is_store_i,
    output ptw_req_valid_o,
    input  ptw_req_ready_i,
    output ptw_req_vaddr_o,
    output ptw_req_is_instr_o,
    output ptw_req_is_store_o,
    input  ptw_done_i,
    input  ptw_error_i,
    output itlb_done_o,
    output dtlb_done_o,
    output done_error_o,
    output ptw_busy_o,
    output itlb_walk_cnt_o,
    output dtlb_walk_cnt_o
  );

  modport slave (
    output flush_i,
    output itlb_miss_i,
    output itlb_vaddr_i,
    output dtlb_miss_i,
    output dtlb_vaddr_i,
    output dtlb_is_store_i,
    input  ptw_req_valid_o,
    output ptw_req_ready_i,
    input  ptw_req_vaddr_o,
    input  ptw_req_is_instr_o,
    input  ptw_req_is_store_o,
    output ptw_done_i,
    output ptw_error_i,
    input  itlb_done_o,
    input  dtlb_done_o,
    input  done_error_o,
    input  ptw_busy_o,
    input  itlb_walk_cnt_o,
    input  dtlb_walk_cnt_o
  );

endinterface

// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter
// Arbitrates I-TLB and D-TLB miss requests onto the single Sv32 page-table
// walker. One walk is in flight at a time; ties are broken round-robin, the
// grant is held until the walker reports completion, and a flush abandons any
// pending or in-flight walk (an already-accepted walk is drained silently).
// Saturating per-source counters of accepted walks feed the perf counters.
//
// Parameters:
//   VLEN  - virtual address width; must match the interface instance
//   CNT_W - walk counter width; must match the interface instance
//
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - ptw_req_arbiter_if.master (TLB misses, walker handshake,
//            completion pulses, busy flag and walk counters)
module ptw_req_arbiter #(
  parameter int VLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ptw_req_arbiter_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WALK  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic             last_is_instr_q;
  logic             is_instr_q;
  logic             is_store_q;
  logic             valid_q;
  logic             busy_q;
  logic [VLEN-1:0]  vaddr_q;
  logic [CNT_W-1:0] itlb_cnt_q;
  logic [CNT_W-1:0] dtlb_cnt_q;

  logic             grant_instr;
  logic             walk_done;

  // I wins when it is the only requester, or on a tie when D went last.
  assign grant_instr = bus.itlb_miss_i &
                       (~bus.dtlb_miss_i | ~last_is_instr_q);

  // valid/busy are registered alongside the state so they always equal
  // (state==REQ) and (state!=IDLE) without decoding the state on the output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      last_is_instr_q <= 1'b1;
      is_instr_q      <= 1'b0;
      is_store_q      <= 1'b0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      vaddr_q         <= '0;
      itlb_cnt_q      <= '0;
      dtlb_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush_i && (bus.itlb_miss_i || bus.dtlb_miss_i)) begin
            state_q    <= REQ;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            is_instr_q <= grant_instr;
            is_store_q <= ~grant_instr & bus.dtlb_is_store_i;
            vaddr_q    <= grant_instr ? bus.itlb_vaddr_i : bus.dtlb_vaddr_i;
          end
        end

        REQ: begin
          if (bus.ptw_req_ready_i) begin
            // Accepted by the walker: it counts even if a flush arrives in
            // the same cycle, in which case the result is drained unseen.
            valid_q         <= 1'b0;
            last_is_instr_q <= is_instr_q;
            state_q         <= bus.flush_i ? DRAIN : WALK;
            if (is_instr_q) begin
              if (itlb_cnt_q != CNT_MAX) itlb_cnt_q <= itlb_cnt_q + 1'b1;
            end else begin
              if (dtlb_cnt_q != CNT_MAX) dtlb_cnt_q <= dtlb_cnt_q + 1'b1;
            end
          end else if (bus.flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        WALK: begin
          if (bus.ptw_done_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.flush_i) begin
            state_q <= DRAIN;
          end
        end

        DRAIN: begin
          // Flush is irrelevant here: the walk is already abandoned.
          if (bus.ptw_done_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally; a flush in the done cycle
  // suppresses it because the requester is about to drop the miss anyway.
  assign walk_done = (state_q == WALK) & bus.ptw_done_i & ~bus.flush_i;

  assign bus.itlb_done_o        = walk_done & is_instr_q;
  assign bus.dtlb_done_o        = walk_done & ~is_instr_q;
  assign bus.done_error_o       = walk_done & bus.ptw_error_i;

  assign bus.ptw_req_valid_o    = valid_q;
  assign bus.ptw_busy_o         = busy_q;
  assign bus.ptw_req_vaddr_o    = vaddr_q;
  assign bus.ptw_req_is_instr_o = is_instr_q;
  assign bus.ptw_req_is_store_o = is_store_q;
  assign bus.itlb_walk_cnt_o    = itlb_cnt_q;
  assign bus.dtlb_walk_cnt_o    = dtlb_cnt_q;

  // The walker may only report completion for a walk it has accepted.
  a_done_only_when_walking: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.ptw_done_i |-> (state_q == WALK || state_q == DRAIN)
  );

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// tb_ptw_req_arbiter
// Self-checking bench for ptw_req_arbiter. Expected grants are queued when
// misses are raised and compared at the walker handshake; done pulses and
// counters are compared against a small bench-side model. A second copy of
// the arbiter with 4-bit counters shares all inputs so counter saturation is
// reached in a handful of walks.
module tb_ptw_req_arbiter;

  logic clk_i;
  logic rst_ni;

  ptw_req_arbiter_if #(.VLEN(32), .CNT_W(16)) bus ();
  ptw_req_arbiter_if #(.VLEN(32), .CNT_W(4))  nbus ();

  ptw_req_arbiter #(.VLEN(32), .CNT_W(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  ptw_req_arbiter #(.VLEN(32), .CNT_W(4)) dut_narrow (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (nbus)
  );

  assign nbus.flush_i         = bus.flush_i;
  assign nbus.itlb_miss_i     = bus.itlb_miss_i;
  assign nbus.itlb_vaddr_i    = bus.itlb_vaddr_i;
  assign nbus.dtlb_miss_i     = bus.dtlb_miss_i;
  assign nbus.dtlb_vaddr_i    = bus.dtlb_vaddr_i;
  assign nbus.dtlb_is_store_i = bus.dtlb_is_store_i;
  assign nbus.ptw_req_ready_i = bus.ptw_req_ready_i;
  assign nbus.ptw_done_i      = bus.ptw_done_i;
  assign nbus.ptw_error_i     = bus.ptw_error_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] vaddr;
    bit          is_instr;
    bit          is_store;
  } grant_t;

  grant_t exp_q[$];
  grant_t cur;
  int     checks;
  int     errors;
  int     i_acc;
  int     d_acc;
  bit     model_last_instr;
  bit     exp_i_pulse;
  bit     exp_d_pulse;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  // Raise misses and queue the grants in the order the round-robin should
  // issue them, based on the last accepted source.
  task automatic applyStimulus(input bit i_miss, input logic [31:0] iva,
                               input bit d_miss, input logic [31:0] dva,
                               input bit store);
    grant_t gi;
    grant_t gd;
    gi = '{vaddr: iva, is_instr: 1'b1, is_store: 1'b0};
    gd = '{vaddr: dva, is_instr: 1'b0, is_store: store};
    if (i_miss) begin
      bus.itlb_vaddr_i = iva;
      bus.itlb_miss_i  = 1'b1;
    end
    if (d_miss) begin
      bus.dtlb_vaddr_i    = dva;
      bus.dtlb_is_store_i = store;
      bus.dtlb_miss_i     = 1'b1;
    end
    if (i_miss && d_miss) begin
      if (model_last_instr) begin
        exp_q.push_back(gd);
        exp_q.push_back(gi);
      end else begin
        exp_q.push_back(gi);
        exp_q.push_back(gd);
      end
    end else if (i_miss) begin
      exp_q.push_back(gi);
    end else if (d_miss) begin
      exp_q.push_back(gd);
    end
  endtask

  // One clock: sample at the falling edge, then apply requester reactions
  // and clear single-cycle inputs just after the rising edge.
  task automatic cycle();
    bit     ip;
    bit     dp;
    grant_t e;
    @(negedge clk_i);
    ip = exp_i_pulse;
    dp = exp_d_pulse;
    if (bus.ptw_req_valid_o && bus.ptw_req_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_grant", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("grant_vaddr", bus.ptw_req_vaddr_o, e.vaddr);
        checkOutput("grant_is_instr", bus.ptw_req_is_instr_o, e.is_instr);
        checkOutput("grant_is_store", bus.ptw_req_is_store_o, e.is_store);
        model_last_instr = e.is_instr;
        if (e.is_instr) i_acc++;
        else d_acc++;
        cur = e;
      end
    end
    checkOutput("itlb_done", bus.itlb_done_o, ip);
    checkOutput("dtlb_done", bus.dtlb_done_o, dp);
    checkOutput("done_error", bus.done_error_o,
                (ip | dp) ? bus.ptw_error_i : 1'b0);
    @(posedge clk_i);
    #1;
    if (ip) bus.itlb_miss_i = 1'b0;
    if (dp) bus.dtlb_miss_i = 1'b0;
    exp_i_pulse     = 1'b0;
    exp_d_pulse     = 1'b0;
    bus.ptw_done_i  = 1'b0;
    bus.ptw_error_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ptw_req_valid_o) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    if (!ok) checkOutput("valid_timeout", 32'd0, 32'd1);
  endtask

  // Serve one grant: handshake with ready high, walk for lat cycles, done.
  task automatic doWalk(input int lat, input bit err);
    bit ok;
    waitValid(ok);
    if (ok) begin
      cycle();
      checkOutput("valid_one_cycle", bus.ptw_req_valid_o, 1'b0);
      checkOutput("busy_in_walk", bus.ptw_busy_o, 1'b1);
      repeat (lat - 1) cycle();
      bus.ptw_done_i  = 1'b1;
      bus.ptw_error_i = err;
      if (cur.is_instr) exp_i_pulse = 1'b1;
      else exp_d_pulse = 1'b1;
      cycle();
      checkOutput("busy_after_done", bus.ptw_busy_o, 1'b0);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_icnt"},  bus.itlb_walk_cnt_o,  sat(i_acc, 16));
    checkOutput({tag, "_dcnt"},  bus.dtlb_walk_cnt_o,  sat(d_acc, 16));
    checkOutput({tag, "_nicnt"}, nbus.itlb_walk_cnt_o, sat(i_acc, 4));
    checkOutput({tag, "_ndcnt"}, nbus.dtlb_walk_cnt_o, sat(d_acc, 4));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"},    bus.ptw_req_valid_o,    32'd0);
    checkOutput({tag, "_busy"},     bus.ptw_busy_o,         32'd0);
    checkOutput({tag, "_vaddr"},    bus.ptw_req_vaddr_o,    32'd0);
    checkOutput({tag, "_is_instr"}, bus.ptw_req_is_instr_o, 32'd0);
    checkOutput({tag, "_is_store"}, bus.ptw_req_is_store_o, 32'd0);
    checkOutput({tag, "_idone"},    bus.itlb_done_o,        32'd0);
    checkOutput({tag, "_ddone"},    bus.dtlb_done_o,        32'd0);
    checkOutput({tag, "_derr"},     bus.done_error_o,       32'd0);
    checkOutput({tag, "_icnt"},     bus.itlb_walk_cnt_o,    32'd0);
    checkOutput({tag, "_dcnt"},     bus.dtlb_walk_cnt_o,    32'd0);
    checkOutput({tag, "_nicnt"},    nbus.itlb_walk_cnt_o,   32'd0);
    checkOutput({tag, "_ndcnt"},    nbus.dtlb_walk_cnt_o,   32'd0);
  endtask

  task automatic resetModel();
    i_acc            = 0;
    d_acc            = 0;
    model_last_instr = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    checks              = 0;
    errors              = 0;
    exp_i_pulse         = 1'b0;
    exp_d_pulse         = 1'b0;
    resetModel();
    rst_ni              = 1'b0;
    bus.flush_i         = 1'b0;
    bus.itlb_miss_i     = 1'b0;
    bus.itlb_vaddr_i    = '0;
    bus.dtlb_miss_i     = 1'b0;
    bus.dtlb_vaddr_i    = '0;
    bus.dtlb_is_store_i = 1'b0;
    bus.ptw_req_ready_i = 1'b1;
    bus.ptw_done_i      = 1'b0;
    bus.ptw_error_i     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #3;
    checkAllZero("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single I miss, ready held high, done after 5 cycles
    applyStimulus(1'b1, 32'h8000_1000, 1'b0, 32'h0, 1'b0);
    doWalk(5, 1'b0);
    checkCounters("single_i");

    // Simultaneous pair: D (store) first because I was granted last
    applyStimulus(1'b1, 32'h8000_3000, 1'b1, 32'h8000_2000, 1'b1);
    doWalk(3, 1'b0);
    doWalk(3, 1'b0);

    // Four back-to-back pairs alternate D,I; some walks report errors
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 32'h8010_0000 + (k << 12), 1'b1,
                    32'h8020_0000 + (k << 12), k[0]);
      doWalk(2, k[1]);
      doWalk(2, k[0]);
    end
    checkCounters("pairs");

    // D alone, then a pair: I now wins the tie
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8030_0000, 1'b0);
    doWalk(2, 1'b0);
    applyStimulus(1'b1, 32'h8031_0000, 1'b1, 32'h8032_0000, 1'b1);
    doWalk(2, 1'b0);
    doWalk(2, 1'b1);
    checkCounters("rr_flip");

    // REQ with ready low for 3 cycles, flush in cycle 2; address held stable
    bus.ptw_req_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h8000_4000, 1'b0, 32'h0, 1'b0);
    waitValid(ok);
    bus.itlb_vaddr_i = 32'hDEAD_0000;
    cycle();
    checkOutput("req_valid_hold", bus.ptw_req_valid_o, 1'b1);
    checkOutput("req_vaddr_stable", bus.ptw_req_vaddr_o, 32'h8000_4000);
    bus.flush_i     = 1'b1;
    bus.itlb_miss_i = 1'b0;
    cycle();
    checkOutput("flush_req_valid", bus.ptw_req_valid_o, 1'b0);
    checkOutput("flush_req_busy", bus.ptw_busy_o, 1'b0);
    cycle();
    checkCounters("flush_req");
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    bus.ptw_req_ready_i = 1'b1;

    // Flush in WALK, done with error 3 cycles later: drained silently
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_5000, 1'b0);
    waitValid(ok);
    cycle();
    cycle();
    bus.flush_i     = 1'b1;
    bus.dtlb_miss_i = 1'b0;
    cycle();
    checkOutput("drain_busy0", bus.ptw_busy_o, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      checkOutput("drain_busy", bus.ptw_busy_o, 1'b1);
    end
    bus.ptw_done_i  = 1'b1;
    bus.ptw_error_i = 1'b1;
    cycle();
    checkOutput("drain_exit_busy", bus.ptw_busy_o, 1'b0);
    checkCounters("flush_walk");

    // Flush and done in the same WALK cycle: no pulse, idle next cycle
    applyStimulus(1'b1, 32'h8000_6000, 1'b0, 32'h0, 1'b0);
    waitValid(ok);
    cycle();
    cycle();
    bus.ptw_done_i  = 1'b1;
    bus.flush_i     = 1'b1;
    bus.itlb_miss_i = 1'b0;
    cycle();
    checkOutput("flush_done_busy", bus.ptw_busy_o, 1'b0);

    // Flush together with ready in REQ: accepted, counted, drained
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_7000, 1'b1);
    waitValid(ok);
    bus.flush_i     = 1'b1;
    bus.dtlb_miss_i = 1'b0;
    cycle();
    checkOutput("flush_rdy_busy", bus.ptw_busy_o, 1'b1);
    checkOutput("flush_rdy_valid", bus.ptw_req_valid_o, 1'b0);
    cycle();
    bus.ptw_done_i = 1'b1;
    cycle();
    checkOutput("flush_rdy_idle", bus.ptw_busy_o, 1'b0);
    checkCounters("flush_rdy");

    // Run D walks past the narrow counter's all-ones value
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h9000_0000 + (k << 12), k[0]);
      doWalk(1, 1'b0);
    end
    checkCounters("saturate");
    checkOutput("narrow_d_at_max", nbus.dtlb_walk_cnt_o, 32'hF);

    // Asynchronous reset in the middle of a walk
    applyStimulus(1'b1, 32'h8000_8000, 1'b0, 32'h0, 1'b0);
    waitValid(ok);
    cycle();
    cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("rst_mid");
    bus.itlb_miss_i = 1'b0;
    resetModel();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // After reset D wins the first tie again
    applyStimulus(1'b1, 32'h8000_A000, 1'b1, 32'h8000_B000, 1'b1);
    doWalk(2, 1'b0);
    doWalk(2, 1'b1);
    checkCounters("post_reset");

    cycle();
    checkOutput("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_req_arbiter.md
Name: ptw_req_arbiter

Overview:
- Arbitrates I-TLB and D-TLB miss requests onto the single Sv32 page-table walker in the MMU (InstrTlbEntries=2, DataTlbEntries=2 per core config).
- Grants one walk at a time with round-robin fairness, holds the grant until the walker reports completion, and handles flush mid-walk.
- Provides saturating per-source walk counters for the perf-counter block.

Parameters:
- VLEN, 32, virtual address width (Sv32).
- CNT_W, 16, width of each saturating walk counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  sfence.vma / mode-change flush; abandons any pending or in-flight walk
- itlb_miss_i  in  1  I-TLB miss level; held until itlb_done_o or flush
- itlb_vaddr_i  in  VLEN  I-TLB miss address
- dtlb_miss_i  in  1  D-TLB miss level; held until dtlb_done_o or flush
- dtlb_vaddr_i  in  VLEN  D-TLB miss address
- dtlb_is_store_i  in  1  D-TLB miss caused by a store or AMO
- ptw_req_valid_o  out  1  walk request valid
- ptw_req_ready_i  in  1  walker accepts request
- ptw_req_vaddr_o  out  VLEN  captured miss address
- ptw_req_is_instr_o  out  1  1 = instruction walk
- ptw_req_is_store_o  out  1  store walk (0 for instruction walks)
- ptw_done_i  in  1  walk finished (update or fault), single-cycle pulse
- ptw_error_i  in  1  qualifies ptw_done_i: page fault or access fault
- itlb_done_o  out  1  single-cycle completion pulse to the I-TLB
- dtlb_done_o  out  1  single-cycle completion pulse to the D-TLB
- done_error_o  out  1  equals ptw_error_i whenever either done pulse is high, else 0
- ptw_busy_o  out  1  state != IDLE
- itlb_walk_cnt_o  out  CNT_W  accepted I-walks, saturating
- dtlb_walk_cnt_o  out  CNT_W  accepted D-walks, saturating

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - last_grant = I, so D wins the first tie.
  - All outputs 0; captured vaddr, is_instr and is_store registers 0; counters 0.
- FSM states: IDLE, REQ, WALK, DRAIN.
- IDLE:
  - If `flush_i`=1, stay in IDLE.
  - Otherwise, if either miss is high, grant and go to REQ next cycle. Capture vaddr, is_instr and is_store from the granted source in that same edge.
  - Only I missing grants I; only D missing grants D.
  - If both miss, grant the source that is not last_grant.
- REQ:
  - `ptw_req_valid_o`=1; vaddr, is_instr and is_store are stable while valid is high.
  - Handshake with no flush: on valid&ready, go to WALK. Set last_grant to the granted source and increment its counter, saturating at all-ones.
  - Flush without ready: go to IDLE with no counter change. Valid deasserts in the next cycle.
  - Flush together with ready: the request was accepted. Go to DRAIN and increment the counter.
- WALK:
  - `ptw_done_i` with no flush: pulse the granted source's done output combinationally in the same cycle, drive done_error_o, and go to IDLE.
  - Flush without done: go to DRAIN.
  - Flush together with done: go to IDLE and suppress the done pulse.
- DRAIN:
  - Wait for `ptw_done_i`, then go to IDLE.
  - No done pulse is issued; the result is discarded.
  - `flush_i` is ignored in this state.
- Re-grant latency: a requester deasserts its miss one cycle after its done pulse. IDLE in cycle N+1 therefore sees the updated level, and a new grant is issued no earlier than N+1, with valid at N+2.
- Outputs are registered or pure functions of state: `ptw_req_valid_o` = (state==REQ); `ptw_busy_o` = (state!=IDLE). The done pulses and `done_error_o` are the only combinational paths from inputs.
- Miss inputs are not sampled outside IDLE. The captured address is not updated if a requester changes vaddr mid-walk.
- `ptw_done_i` in IDLE or REQ is protocol-illegal; it is ignored and flagged by an assertion.
- Asynchronous reset mid-walk returns to IDLE immediately. No done pulse is issued and the counters clear.

Test Plan:
- Single I miss at vaddr 0x8000_1000, ready held 1, done after 5 cycles with error 0 → valid for 1 cycle; ptw_req_vaddr_o=0x8000_1000, is_instr=1; itlb_done_o pulses exactly once; itlb_walk_cnt_o=1.
- I and D miss in the same cycle after reset, D store at 0x8000_2000 → D granted first with is_store=1. After dtlb_done_o, I is granted next. Issue 4 back-to-back simultaneous pairs → grants alternate D,I,D,I,… and both counters are equal.
- ready held 0 for 3 cycles with flush on cycle 2 → valid drops, state IDLE, no counter increment, no done pulse.
- Flush during WALK, then ptw_done_i with error=1 3 cycles later → DRAIN; neither done pulse fires; done_error_o stays 0; ptw_busy_o stays 1 until the done cycle.
- Flush and ptw_done_i in the same WALK cycle → no done pulse, IDLE next cycle. Separately, flush together with ready in REQ → DRAIN, counter incremented.
- Preload dtlb_walk_cnt_o to 0xFFFF via 65535 walks (or a forced value), then one more walk → counter holds at 0xFFFF. Assert rst_ni low mid-walk → all outputs 0 immediately.
